fft_pingpong_buffer: RTL and testbench

Dual-port ping-pong working store for one radix-2 FFT stage, with two read and two write ports so a butterfly fetches and retires both operands per cycle.
Words are WORD_W bits. In fp8 mode a word is one complex sample. In fp4 mode a word is split into LANES packed sub-words, with per-lane write masks.
Bank swap is a req/ack handshake with the stage controller. A background clear engine zeroes the write bank.
Sits between the stage controller and the butterfly/twiddle datapath.

---
 rtl/fft_mem_pkg.sv | 26 ++
 rtl/fft_mem_bank.sv | 48 ++++
 rtl/fft_pingpong_buffer.sv | 153 +++++++++++++++
 tb/tb_fft_pingpong_buffer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_mem_pkg.sv
// Shared types and helpers for the FFT ping-pong working store.
// Lane masks expand into per-bit write enables for the memory banks.
package fft_mem_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SWAP, ST_CLEAR} state_t;

   localparam int MAX_W     = 256;
   localparam int MAX_LANES = 32;
   localparam int BIDX_W    = $clog2(MAX_W);
   localparam int LIDX_W    = $clog2(MAX_LANES);

   function automatic int lane_w(input int word_w, input int lanes);
      return word_w / lanes;
   endfunction

   // Bits at and above word_w come back as zero.
   function automatic logic [MAX_W-1:0] expand_mask(input logic [MAX_LANES-1:0] mask,
                                                    input int word_w, input int lanes);
      logic [MAX_W-1:0] bits;
      bits = '0;
      for (int i = 0; i < MAX_W; i++)
         if (i < word_w) bits[BIDX_W'(i)] = mask[LIDX_W'(i / lane_w(word_w, lanes))];
      return bits;
   endfunction

endpackage

// File: rtl/fft_mem_bank.sv
// One N x WORD_W bank: two bit-masked write ports (B overrides A on overlap)
// and two registered read ports; out-of-range reads return zero.
module fft_mem_bank
   import fft_mem_pkg::*;
#(
   parameter int N          = 1024,
   parameter int ADDR_WIDTH = $clog2(N),
   parameter int WORD_W     = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0]                       wr_en,
   input  logic [1:0][ADDR_WIDTH-1:0]       wr_addr,
   input  logic [1:0][WORD_W-1:0]           wr_data,
   input  logic [1:0][WORD_W-1:0]           wr_bmask,
   input  logic [1:0]                       rd_en,
   input  logic [1:0][ADDR_WIDTH-1:0]       rd_addr,
   output logic [1:0][WORD_W-1:0]           rd_data
);

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(N);

   logic [WORD_W-1:0] mem [N];
   logic [WORD_W-1:0] merged_a, merged_b, base_b;

   // B merges on top of A's result when both hit the same word.
   always_comb begin
      merged_a = (mem[wr_addr[0]] & ~wr_bmask[0]) | (wr_data[0] & wr_bmask[0]);
      base_b   = (wr_en[0] && wr_addr[0] == wr_addr[1]) ? merged_a : mem[wr_addr[1]];
      merged_b = (base_b & ~wr_bmask[1]) | (wr_data[1] & wr_bmask[1]);
   end

   always_ff @(posedge clk) begin
      if (wr_en[0]) mem[wr_addr[0]] <= merged_a;
      if (wr_en[1]) mem[wr_addr[1]] <= merged_b;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else begin
         for (int p = 0; p < 2; p++)
            if (rd_en[p])
               rd_data[p] <= ({1'b0, rd_addr[p]} < DEPTH) ? mem[rd_addr[p]] : '0;
      end
   end

endmodule

// File: rtl/fft_pingpong_buffer.sv
// Ping-pong working store for one radix-2 FFT stage: two banks, swap
// handshake, background clear engine and write-collision detection.
module fft_pingpong_buffer
   import fft_mem_pkg::*;
#(
   parameter int N          = 1024,
   parameter int ADDR_WIDTH = $clog2(N),
   parameter int WORD_W     = 16,
   parameter int LANES      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode_fp4,
   input  logic                  rd_en_a,
   input  logic                  rd_en_b,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [WORD_W-1:0]     rd_data_a,
   output logic [WORD_W-1:0]     rd_data_b,
   output logic                  rd_valid_a,
   output logic                  rd_valid_b,
   input  logic                  wr_en_a,
   input  logic                  wr_en_b,
   input  logic [ADDR_WIDTH-1:0] wr_addr_a,
   input  logic [ADDR_WIDTH-1:0] wr_addr_b,
   input  logic [WORD_W-1:0]     wr_data_a,
   input  logic [WORD_W-1:0]     wr_data_b,
   input  logic [LANES-1:0]      wr_mask_a,
   input  logic [LANES-1:0]      wr_mask_b,
   input  logic                  swap_req,
   output logic                  swap_ack,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  bank_sel,
   output logic                  wr_collision
);

   localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(N);
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(N - 1);

   state_t                         state, state_nxt;
   logic [ADDR_WIDTH-1:0]          clr_cnt;
   logic                           clear_acc, collide;
   logic [MAX_W-1:0]               exp_a, exp_b;
   logic [1:0]                     ext_ok;
   logic [1:0][WORD_W-1:0]         ext_bmask;
   logic [1:0]                     bk_wr_en;
   logic [1:0][ADDR_WIDTH-1:0]     bk_wr_addr;
   logic [1:0][WORD_W-1:0]         bk_wr_data;
   logic [1:0][WORD_W-1:0]         bk_wr_bmask;
   logic [1:0][1:0][WORD_W-1:0]    bank_rd;
   logic                           rd_bank_a, rd_bank_b;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next state: clear beats swap; CLEAR spans exactly N cycles.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (clear_req)          state_nxt = ST_CLEAR;
                   else if (swap_req)      state_nxt = ST_SWAP;
         ST_SWAP:                          state_nxt = ST_IDLE;
         ST_CLEAR: if (clr_cnt == LAST)    state_nxt = ST_IDLE;
         default:                          state_nxt = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      swap_ack  = (state == ST_SWAP);
      busy      = (state == ST_CLEAR);
      clear_acc = (state == ST_IDLE) && clear_req;
   end

   always_comb begin
      exp_a        = expand_mask(MAX_LANES'(wr_mask_a), WORD_W, LANES);
      exp_b        = expand_mask(MAX_LANES'(wr_mask_b), WORD_W, LANES);
      ext_bmask[0] = mode_fp4 ? exp_a[WORD_W-1:0] : '1;
      ext_bmask[1] = mode_fp4 ? exp_b[WORD_W-1:0] : '1;
      ext_ok[0]    = wr_en_a && ({1'b0, wr_addr_a} < DEPTH) && (state != ST_CLEAR);
      ext_ok[1]    = wr_en_b && ({1'b0, wr_addr_b} < DEPTH) && (state != ST_CLEAR);
      collide      = (&ext_ok) && (wr_addr_a == wr_addr_b) && (|(ext_bmask[0] & ext_bmask[1]));
   end

   // The clear engine borrows write port A; external writes are dropped meanwhile.
   always_comb begin
      if (state == ST_CLEAR) begin
         bk_wr_en    = 2'b01;
         bk_wr_addr  = {wr_addr_b, clr_cnt};
         bk_wr_data  = '0;
         bk_wr_bmask = {ext_bmask[1], {WORD_W{1'b1}}};
      end else begin
         bk_wr_en    = ext_ok;
         bk_wr_addr  = {wr_addr_b, wr_addr_a};
         bk_wr_data  = {wr_data_b, wr_data_a};
         bk_wr_bmask = ext_bmask;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_sel     <= 1'b0;
         clr_cnt      <= '0;
         wr_collision <= 1'b0;
      end else begin
         if (state == ST_SWAP) bank_sel <= ~bank_sel;
         clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
         if (clear_acc)    wr_collision <= 1'b0;
         else if (collide) wr_collision <= 1'b1;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_mem_bank #(
         .N          (N),
         .ADDR_WIDTH (ADDR_WIDTH),
         .WORD_W     (WORD_W)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (bk_wr_en & {2{bank_sel != 1'(b)}}),
         .wr_addr  (bk_wr_addr),
         .wr_data  (bk_wr_data),
         .wr_bmask (bk_wr_bmask),
         .rd_en    ({rd_en_b, rd_en_a} & {2{bank_sel == 1'(b)}}),
         .rd_addr  ({rd_addr_b, rd_addr_a}),
         .rd_data  (bank_rd[b])
      );
   end

   // Remember which bank each read went to so data holds between reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid_a <= 1'b0;
         rd_valid_b <= 1'b0;
         rd_bank_a  <= 1'b0;
         rd_bank_b  <= 1'b0;
      end else begin
         rd_valid_a <= rd_en_a;
         rd_valid_b <= rd_en_b;
         if (rd_en_a) rd_bank_a <= bank_sel;
         if (rd_en_b) rd_bank_b <= bank_sel;
      end
   end

   assign rd_data_a = bank_rd[rd_bank_a][0];
   assign rd_data_b = bank_rd[rd_bank_b][1];

endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// Scoreboard bench for fft_pingpong_buffer (N=16, WORD_W=16, LANES=2):
// reads push expected data, per-port monitors pop on rd_valid.
module tb_fft_pingpong_buffer;

   localparam int N  = 16;
   localparam int AW = 4;
   localparam int W  = 16;
   localparam int L  = 2;

   logic          clk, rst, mode_fp4;
   logic          rd_en_a, rd_en_b, rd_valid_a, rd_valid_b;
   logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [W-1:0]  rd_data_a, rd_data_b, wr_data_a, wr_data_b;
   logic          wr_en_a, wr_en_b;
   logic [L-1:0]  wr_mask_a, wr_mask_b;
   logic          swap_req, swap_ack, clear_req, busy, bank_sel, wr_collision;

   typedef struct {
      logic [W-1:0] data;
      bit           dc;
      int           cyc;
   } exp_t;

   exp_t qa[$], qb[$];
   exp_t ea, eb;
   int   comps = 0, fails = 0, cyc = 0;

   fft_pingpong_buffer #(.N(N), .ADDR_WIDTH(AW), .WORD_W(W), .LANES(L)) dut (
      .clk(clk), .rst(rst), .mode_fp4(mode_fp4),
      .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
      .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
      .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
      .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
      .wr_mask_a(wr_mask_a), .wr_mask_b(wr_mask_b),
      .swap_req(swap_req), .swap_ack(swap_ack),
      .clear_req(clear_req), .busy(busy),
      .bank_sel(bank_sel), .wr_collision(wr_collision)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      comps++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor A
   always @(negedge clk) begin
      if (rd_valid_a === 1'b1) begin
         comps++;
         if (qa.size() == 0) begin
            fails++;
            $display("FAIL rd_a_unexpected: got valid data 0x%0h expected no read", rd_data_a);
         end else begin
            ea = qa.pop_front();
            if (cyc != ea.cyc + 1) begin
               fails++;
               $display("FAIL rd_a_latency: got cycle %0d expected %0d", cyc, ea.cyc + 1);
            end
            if (!ea.dc) begin
               comps++;
               if (rd_data_a !== ea.data) begin
                  fails++;
                  $display("FAIL rd_a_data: got 0x%0h expected 0x%0h", rd_data_a, ea.data);
               end
            end
         end
      end else if (qa.size() > 0 && cyc > qa[0].cyc + 1) begin
         comps++;
         fails++;
         $display("FAIL rd_a_missing: got no valid expected valid at cycle %0d", qa[0].cyc + 1);
         void'(qa.pop_front());
      end
   end

   // Monitor B
   always @(negedge clk) begin
      if (rd_valid_b === 1'b1) begin
         comps++;
         if (qb.size() == 0) begin
            fails++;
            $display("FAIL rd_b_unexpected: got valid data 0x%0h expected no read", rd_data_b);
         end else begin
            eb = qb.pop_front();
            if (cyc != eb.cyc + 1) begin
               fails++;
               $display("FAIL rd_b_latency: got cycle %0d expected %0d", cyc, eb.cyc + 1);
            end
            if (!eb.dc) begin
               comps++;
               if (rd_data_b !== eb.data) begin
                  fails++;
                  $display("FAIL rd_b_data: got 0x%0h expected 0x%0h", rd_data_b, eb.data);
               end
            end
         end
      end else if (qb.size() > 0 && cyc > qb[0].cyc + 1) begin
         comps++;
         fails++;
         $display("FAIL rd_b_missing: got no valid expected valid at cycle %0d", qb[0].cyc + 1);
         void'(qb.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_a(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [L-1:0] m);
      wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d; wr_mask_a = m;
      tick();
      wr_en_a = 1'b0;
   endtask

   task automatic read_a(input logic [AW-1:0] a, input logic [W-1:0] d, input bit dc);
      rd_en_a = 1'b1; rd_addr_a = a;
      qa.push_back('{data: d, dc: dc, cyc: cyc});
      tick();
      rd_en_a = 1'b0;
   endtask

   task automatic read_b(input logic [AW-1:0] a, input logic [W-1:0] d);
      rd_en_b = 1'b1; rd_addr_b = a;
      qb.push_back('{data: d, dc: 1'b0, cyc: cyc});
      tick();
      rd_en_b = 1'b0;
   endtask

   task automatic do_swap(input logic exp_sel);
      swap_req = 1'b1;
      tick();
      check("swap_ack_pulse", swap_ack, 1);
      swap_req = 1'b0;
      tick();
      check("swap_bank_sel", bank_sel, exp_sel);
      check("swap_ack_drop", swap_ack, 0);
   endtask

   initial begin
      int n, acks;
      rst = 1'b1; mode_fp4 = 1'b0;
      rd_en_a = 0; rd_en_b = 0; rd_addr_a = '0; rd_addr_b = '0;
      wr_en_a = 0; wr_en_b = 0; wr_addr_a = '0; wr_addr_b = '0;
      wr_data_a = '0; wr_data_b = '0; wr_mask_a = '0; wr_mask_b = '0;
      swap_req = 0; clear_req = 0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bank_sel", bank_sel, 0);
      check("rst_busy", busy, 0);
      check("rst_swap_ack", swap_ack, 0);
      check("rst_collision", wr_collision, 0);
      check("rst_rd_valid_a", rd_valid_a, 0);
      check("rst_rd_data_a", rd_data_a, 0);
      rst = 1'b1;
      tick();

      // Ping-pong
      write_a(4'd3, 16'hA5C3, 2'b11);
      read_a(4'd3, 16'h0000, 1'b1);
      tick();
      do_swap(1'b1);
      read_a(4'd3, 16'hA5C3, 1'b0);
      tick();
      check("rd_data_hold", rd_data_a, 16'hA5C3);

      // fp4 lanes
      mode_fp4 = 1'b1;
      write_a(4'd5, 16'h1234, 2'b01);
      write_a(4'd5, 16'hABCD, 2'b10);
      do_swap(1'b0);
      read_a(4'd5, 16'hAB34, 1'b0);

      // Disjoint lanes, then overlapping lanes
      wr_en_a = 1; wr_addr_a = 4'd9; wr_data_a = 16'h00AA; wr_mask_a = 2'b01;
      wr_en_b = 1; wr_addr_b = 4'd9; wr_data_b = 16'hBB00; wr_mask_b = 2'b10;
      tick();
      check("disjoint_no_collision", wr_collision, 0);
      wr_addr_a = 4'd7; wr_data_a = 16'h1111; wr_mask_a = 2'b11;
      wr_addr_b = 4'd7; wr_data_b = 16'h2222; wr_mask_b = 2'b01;
      tick();
      wr_en_a = 0; wr_en_b = 0;
      check("collision_set", wr_collision, 1);
      do_swap(1'b1);
      read_b(4'd7, 16'h1122);
      read_b(4'd9, 16'hBBAA);
      check("collision_sticky", wr_collision, 1);

      // Fill write bank (bank0) with ones, then clear
      mode_fp4 = 1'b0;
      for (int i = 0; i < N / 2; i++) begin
         wr_en_a = 1; wr_addr_a = AW'(2 * i);     wr_data_a = 16'hFFFF;
         wr_en_b = 1; wr_addr_b = AW'(2 * i + 1); wr_data_b = 16'hFFFF;
         tick();
      end
      wr_en_a = 0; wr_en_b = 0;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("clear_resets_collision", wr_collision, 0);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         wr_en_a = (n == 2); wr_addr_a = 4'd4; wr_data_a = 16'h5555;
         if (n == 5) begin
            rd_en_a = 1'b1; rd_addr_a = 4'd7;
            qa.push_back('{data: 16'h1122, dc: 1'b0, cyc: cyc});
         end else begin
            rd_en_a = 1'b0;
         end
         n++;
         tick();
      end
      wr_en_a = 0; rd_en_a = 0;
      check("clear_busy_cycles", n, N);
      check("clear_bank_sel_kept", bank_sel, 1);
      do_swap(1'b0);
      for (int i = 0; i < N; i++) begin
         rd_en_a = 1'b1; rd_addr_a = AW'(i);
         qa.push_back('{data: 16'h0000, dc: 1'b0, cyc: cyc});
         tick();
      end
      rd_en_a = 1'b0;
      tick();

      // Clear and swap requested together
      clear_req = 1'b1; swap_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("arb_clear_first", busy, 1);
      n = 0; acks = 0;
      while (busy === 1'b1 && n < 100) begin
         if (swap_ack) acks++;
         n++;
         tick();
      end
      check("arb_busy_cycles", n, N);
      check("arb_no_ack_during_busy", acks, 0);
      check("arb_ack_not_yet", swap_ack, 0);
      tick();
      check("arb_ack_after_busy", swap_ack, 1);
      swap_req = 1'b0;
      tick();
      check("arb_bank_sel_toggled", bank_sel, 1);
      tick();
      check("arb_single_toggle", bank_sel, 1);

      // Reset in the middle of a clear
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (8) tick();
      check("midclear_busy", busy, 1);
      rd_en_a = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_bank_sel", bank_sel, 0);
      check("midrst_swap_ack", swap_ack, 0);
      tick();
      check("midrst_rd_valid", rd_valid_a, 0);
      rd_en_a = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check("midrst_idle", busy, 0);

      check("scoreboard_a_drained", qa.size(), 0);
      check("scoreboard_b_drained", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
      $finish;
   end

endmodule
